// File: rtl/l2_pkg.sv
// Shared L2 definitions: cache geometry, DDR app command codes and burst engine states.
package l2_pkg;

   localparam int unsigned L2_AW = 9;
   localparam int unsigned DW    = 128;

   localparam logic [2:0] APP_CMD_WR = 3'b000;
   localparam logic [2:0] APP_CMD_RD = 3'b001;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      DONE
   } l2_state_e;

endpackage

// File: rtl/l2_ddr_skid_fifo.sv
// Two-entry skid FIFO holding L2 lines prefetched ahead of DDR write-data acceptance.
module l2_ddr_skid_fifo
   import l2_pkg::*;
#(
   parameter int unsigned W = DW
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [1:0]   count_o
);

   logic [W-1:0] mem_q [2];
   logic         wptr_q;
   logic         rptr_q;
   logic [1:0]   count_q;
   logic [1:0]   count_d;
   logic         do_push;
   logic         do_pop;

   assign empty_o = (count_q == 2'd0);
   assign full_o  = (count_q == 2'd2);
   assign count_o = count_q;
   assign dout_o  = mem_q[rptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 2'd1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= din_i;
            wptr_q        <= ~wptr_q;
         end
         if (do_pop) begin
            rptr_q <= ~rptr_q;
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/l2_ddr_burst_engine.sv
// Moves bursts of 128-bit lines between L2 port B and the DDR app interface (flush and fill).
module l2_ddr_burst_engine #(
   parameter int unsigned DDR_AW    = 28,
   parameter int unsigned L2_AW     = l2_pkg::L2_AW,
   parameter int unsigned DW        = l2_pkg::DW,
   parameter int unsigned LEN_W     = 8,
   parameter int unsigned ADDR_STEP = 8,
   parameter int unsigned L2_RD_LAT = 1
) (
   input  logic              clk_166M66,
   input  logic              rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_rw,
   input  logic [DDR_AW-1:0] i_req_ddr_addr,
   input  logic [L2_AW-1:0]  i_req_l2_addr,
   input  logic [LEN_W-1:0]  i_req_len,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_l2_en,
   output logic              o_l2_we,
   output logic [L2_AW-1:0]  o_l2_addr,
   output logic [DW-1:0]     o_l2_din,
   input  logic [DW-1:0]     i_l2_dout,
   output logic              o_app_en,
   output logic [2:0]        o_app_cmd,
   output logic [DDR_AW-1:0] o_app_addr,
   input  logic              i_app_rdy,
   output logic              o_app_wdf_wren,
   output logic [DW-1:0]     o_app_wdf_data,
   output logic              o_app_wdf_end,
   input  logic              i_app_wdf_rdy,
   input  logic [DW-1:0]     i_app_rd_data,
   input  logic              i_app_rd_data_valid
);
   import l2_pkg::*;

   l2_state_e            state_q, state_d;
   logic                 rw_q, rw_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [LEN_W-1:0]     cmd_cnt_q, cmd_cnt_d;
   logic [LEN_W-1:0]     data_cnt_q, data_cnt_d;
   logic [LEN_W-1:0]     beat_cnt_q, beat_cnt_d;
   logic [DDR_AW-1:0]    ddr_addr_q, ddr_addr_d;
   logic [L2_AW-1:0]     l2_addr_q, l2_addr_d;
   logic [L2_RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
   logic                 l2_wr_q, l2_wr_d;
   logic [L2_AW-1:0]     l2_wr_addr_q, l2_wr_addr_d;
   logic [DW-1:0]        l2_din_q, l2_din_d;

   logic                 active;
   logic                 cmd_acc;
   logic                 data_acc;
   logic                 wren;
   logic                 l2_rd_issue;
   logic [2:0]           inflight;
   logic [2:0]           occupancy;
   logic                 fifo_push;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [1:0]           fifo_count;
   logic [DW-1:0]        fifo_dout;

   assign active      = (state_q == WRITE) || (state_q == READ);
   assign o_req_ready = (state_q == IDLE);
   assign o_busy      = (state_q != IDLE);
   assign o_done      = (state_q == DONE);

   assign o_app_en   = active && (cmd_cnt_q != len_q);
   assign o_app_cmd  = (o_app_en && rw_q) ? APP_CMD_RD : APP_CMD_WR;
   assign o_app_addr = o_app_en ? ddr_addr_q : '0;
   assign cmd_acc    = o_app_en && i_app_rdy;

   assign wren           = (state_q == WRITE) && !fifo_empty;
   assign o_app_wdf_wren = wren;
   assign o_app_wdf_end  = wren;
   assign o_app_wdf_data = wren ? fifo_dout : '0;
   assign data_acc       = wren && i_app_wdf_rdy;

   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < L2_RD_LAT; i++) begin
         inflight = inflight + {2'b00, rd_pipe_q[i]};
      end
   end

   // Reads still in the BRAM pipeline reserve FIFO slots; a pop this cycle frees one.
   assign occupancy   = {1'b0, fifo_count} + inflight;
   assign l2_rd_issue = (state_q == WRITE) && (beat_cnt_q != len_q) &&
                        ((occupancy - {2'b00, data_acc}) < 3'd2);
   assign fifo_push   = rd_pipe_q[L2_RD_LAT-1] && (!fifo_full || data_acc);

   assign o_l2_en   = l2_rd_issue || l2_wr_q;
   assign o_l2_we   = l2_wr_q;
   assign o_l2_addr = l2_wr_q ? l2_wr_addr_q : (l2_rd_issue ? l2_addr_q : '0);
   assign o_l2_din  = l2_din_q;

   l2_ddr_skid_fifo #(
      .W (DW)
   ) u_skid (
      .clk_i   (clk_166M66),
      .rst_i   (rst),
      .push_i  (fifo_push),
      .din_i   (i_l2_dout),
      .pop_i   (data_acc),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      state_d      = state_q;
      rw_d         = rw_q;
      len_d        = len_q;
      cmd_cnt_d    = cmd_cnt_q;
      data_cnt_d   = data_cnt_q;
      beat_cnt_d   = beat_cnt_q;
      ddr_addr_d   = ddr_addr_q;
      l2_addr_d    = l2_addr_q;
      rd_pipe_d    = rd_pipe_q << 1;
      rd_pipe_d[0] = l2_rd_issue;
      l2_wr_d      = 1'b0;
      l2_wr_addr_d = '0;
      l2_din_d     = '0;

      if (cmd_acc) begin
         cmd_cnt_d  = cmd_cnt_q + LEN_W'(1);
         ddr_addr_d = ddr_addr_q + DDR_AW'(ADDR_STEP);
      end
      if (data_acc) begin
         data_cnt_d = data_cnt_q + LEN_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (i_req_valid) begin
               rw_d       = i_req_rw;
               len_d      = i_req_len;
               ddr_addr_d = i_req_ddr_addr;
               l2_addr_d  = i_req_l2_addr;
               cmd_cnt_d  = '0;
               data_cnt_d = '0;
               beat_cnt_d = '0;
               if (i_req_len == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = i_req_rw ? READ : WRITE;
               end
            end
         end
         WRITE: begin
            if (l2_rd_issue) begin
               beat_cnt_d = beat_cnt_q + LEN_W'(1);
               l2_addr_d  = l2_addr_q + L2_AW'(1);
            end
            if ((cmd_cnt_d == len_q) && (data_cnt_d == len_q)) begin
               state_d = DONE;
            end
         end
         READ: begin
            if (i_app_rd_data_valid) begin
               beat_cnt_d   = beat_cnt_q + LEN_W'(1);
               l2_wr_d      = 1'b1;
               l2_wr_addr_d = l2_addr_q;
               l2_din_d     = i_app_rd_data;
               l2_addr_d    = l2_addr_q + L2_AW'(1);
            end
            if (beat_cnt_d == len_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_166M66 or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         rw_q         <= 1'b0;
         len_q        <= '0;
         cmd_cnt_q    <= '0;
         data_cnt_q   <= '0;
         beat_cnt_q   <= '0;
         ddr_addr_q   <= '0;
         l2_addr_q    <= '0;
         rd_pipe_q    <= '0;
         l2_wr_q      <= 1'b0;
         l2_wr_addr_q <= '0;
         l2_din_q     <= '0;
      end else begin
         state_q      <= state_d;
         rw_q         <= rw_d;
         len_q        <= len_d;
         cmd_cnt_q    <= cmd_cnt_d;
         data_cnt_q   <= data_cnt_d;
         beat_cnt_q   <= beat_cnt_d;
         ddr_addr_q   <= ddr_addr_d;
         l2_addr_q    <= l2_addr_d;
         rd_pipe_q    <= rd_pipe_d;
         l2_wr_q      <= l2_wr_d;
         l2_wr_addr_q <= l2_wr_addr_d;
         l2_din_q     <= l2_din_d;
      end
   end

endmodule
